// File: rtl/decode_stage_pkg.sv
// Shared constants for the RV32I decode stage: opcodes, funct fields, ALU
// operation codes and the small decode helpers used by decode_stage and imm_gen.
package decode_stage_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [2:0] {
        F3_ADD_SUB = 3'b000,
        F3_SLL     = 3'b001,
        F3_SLT     = 3'b010,
        F3_SLTU    = 3'b011,
        F3_XOR     = 3'b100,
        F3_SRL_SRA = 3'b101,
        F3_OR      = 3'b110,
        F3_AND     = 3'b111
    } funct3_e;

    // ALU_ILLEGAL sits far from the real codes so the ALU falls into its default arm.
    typedef enum logic [5:0] {
        ALU_ADD     = 6'd0,
        ALU_SUB     = 6'd1,
        ALU_SLL     = 6'd2,
        ALU_SLT     = 6'd3,
        ALU_SLTU    = 6'd4,
        ALU_XOR     = 6'd5,
        ALU_SRL     = 6'd6,
        ALU_SRA     = 6'd7,
        ALU_OR      = 6'd8,
        ALU_AND     = 6'd9,
        ALU_ADDI    = 6'd10,
        ALU_SLTI    = 6'd11,
        ALU_SLTIU   = 6'd12,
        ALU_XORI    = 6'd13,
        ALU_ORI     = 6'd14,
        ALU_ANDI    = 6'd15,
        ALU_SLLI    = 6'd16,
        ALU_SRLI    = 6'd17,
        ALU_SRAI    = 6'd18,
        ALU_ILLEGAL = 6'h3F
    } alu_op_e;

    // OP-IMM shifts carry a 5-bit shamt instead of a sign-extended immediate.
    function automatic logic is_shift_imm(input logic [31:0] instr);
        return (instr[6:0] == OPC_OP_IMM) &&
               ((instr[14:12] == F3_SLL) || (instr[14:12] == F3_SRL_SRA));
    endfunction

    // funct3 -> op for the register forms whose funct7 must be F7_BASE.
    function automatic alu_op_e op_reg_base(input funct3_e f3);
        case (f3)
            F3_SLL:  return ALU_SLL;
            F3_SLT:  return ALU_SLT;
            F3_SLTU: return ALU_SLTU;
            F3_XOR:  return ALU_XOR;
            F3_OR:   return ALU_OR;
            F3_AND:  return ALU_AND;
            default: return ALU_ILLEGAL;
        endcase
    endfunction

    // funct3 -> op for the immediate forms that ignore instr[31:25].
    function automatic alu_op_e op_imm_plain(input funct3_e f3);
        case (f3)
            F3_ADD_SUB: return ALU_ADDI;
            F3_SLT:     return ALU_SLTI;
            F3_SLTU:    return ALU_SLTIU;
            F3_XOR:     return ALU_XORI;
            F3_OR:      return ALU_ORI;
            F3_AND:     return ALU_ANDI;
            default:    return ALU_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational immediate generator: I-type sign-extended immediate, or the
// zero-extended shamt for OP-IMM shifts.
module imm_gen
    import decode_stage_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm
);

    always_comb begin
        if (is_shift_imm(instr)) begin
            imm = {27'b0, instr[24:20]};
        end else begin
            imm = {{20{instr[31]}}, instr[31:20]};
        end
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I OP / OP-IMM decode stage with a one-entry valid/ready output register.
// Register-file addresses are combinational; operands and control are registered.
module decode_stage
    import decode_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic [31:0] a,
    output logic [31:0] b,
    output logic [5:0]  alu_op,
    output logic [4:0]  rd,
    output logic        rd_we,
    output logic        illegal,
    output logic        out_valid,
    input  logic        out_ready
);

    logic [6:0]  opcode;
    logic [6:0]  funct7;
    funct3_e     funct3;
    logic [4:0]  dec_rd;
    logic [31:0] imm;

    alu_op_e     dec_op;
    logic        dec_legal;
    logic [31:0] dec_a;
    logic [31:0] dec_b;
    logic        accept;

    assign opcode   = instr[6:0];
    assign funct3   = funct3_e'(instr[14:12]);
    assign funct7   = instr[31:25];
    assign dec_rd   = instr[11:7];
    assign rs1_addr = instr[19:15];
    assign rs2_addr = instr[24:20];

    imm_gen u_imm_gen (
        .instr (instr),
        .imm   (imm)
    );

    // Handshake depends only on the output register and out_ready, never on instr.
    assign instr_ready = !out_valid || out_ready;
    assign accept      = instr_valid && instr_ready;

    always_comb begin
        // NOTE: defaults first on every path so this block cannot infer a latch.
        dec_op    = ALU_ILLEGAL;
        dec_legal = 1'b0;
        case (opcode)
            OPC_OP: begin
                case (funct3)
                    F3_ADD_SUB: begin
                        if (funct7 == F7_BASE) begin
                            dec_op    = ALU_ADD;
                            dec_legal = 1'b1;
                        end else if (funct7 == F7_ALT) begin
                            dec_op    = ALU_SUB;
                            dec_legal = 1'b1;
                        end
                    end
                    F3_SRL_SRA: begin
                        if (funct7 == F7_BASE) begin
                            dec_op    = ALU_SRL;
                            dec_legal = 1'b1;
                        end else if (funct7 == F7_ALT) begin
                            dec_op    = ALU_SRA;
                            dec_legal = 1'b1;
                        end
                    end
                    default: begin
                        if (funct7 == F7_BASE) begin
                            dec_op    = op_reg_base(funct3);
                            dec_legal = 1'b1;
                        end
                    end
                endcase
            end
            OPC_OP_IMM: begin
                case (funct3)
                    F3_SLL: begin
                        if (funct7 == F7_BASE) begin
                            dec_op    = ALU_SLLI;
                            dec_legal = 1'b1;
                        end
                    end
                    F3_SRL_SRA: begin
                        if (funct7 == F7_BASE) begin
                            dec_op    = ALU_SRLI;
                            dec_legal = 1'b1;
                        end else if (funct7 == F7_ALT) begin
                            dec_op    = ALU_SRAI;
                            dec_legal = 1'b1;
                        end
                    end
                    default: begin
                        dec_op    = op_imm_plain(funct3);
                        dec_legal = 1'b1;
                    end
                endcase
            end
            default: begin
                dec_op    = ALU_ILLEGAL;
                dec_legal = 1'b0;
            end
        endcase
    end

    // Illegal instructions present zero operands so nothing stale reaches the ALU.
    always_comb begin
        dec_a = '0;
        dec_b = '0;
        if (dec_legal) begin
            dec_a = rs1_data;
            dec_b = (opcode == OPC_OP) ? rs2_data : imm;
        end
    end

    // NOTE: synchronous reset lives inside the clocked block; state uses <= only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            a         <= '0;
            b         <= '0;
            alu_op    <= ALU_ILLEGAL;
            rd        <= '0;
            rd_we     <= 1'b0;
            illegal   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            a         <= dec_a;
            b         <= dec_b;
            alu_op    <= dec_op;
            rd        <= dec_rd;
            rd_we     <= dec_legal && (dec_rd != 5'd0);
            illegal   <= !dec_legal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: table-driven reference decoder plus
// hand-computed literal checks for the key encodings and handshake cases.
module tb_decode_stage;
    import decode_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic [31:0] a, b;
    logic [5:0]  alu_op;
    logic [4:0]  rd;
    logic        rd_we, illegal, out_valid, out_ready;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    decode_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .a           (a),
        .b           (b),
        .alu_op      (alu_op),
        .rd          (rd),
        .rd_we       (rd_we),
        .illegal     (illegal),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference decoder: a list of legal encodings, anything unmatched is illegal.
    typedef struct {
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        bit         f7_care;
        alu_op_e    op;
    } rule_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  op;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } exp_t;

    rule_t rules[$];

    function automatic void add_rule(logic [6:0] opc, logic [2:0] f3, logic [6:0] f7, bit care, alu_op_e op);
        rule_t r;
        r.opc = opc; r.f3 = f3; r.f7 = f7; r.f7_care = care; r.op = op;
        rules.push_back(r);
    endfunction

    function automatic exp_t model(logic [31:0] i, logic [31:0] r1, logic [31:0] r2);
        exp_t    e;
        bit      found;
        alu_op_e op;
        found = 1'b0;
        op    = ALU_ILLEGAL;
        foreach (rules[k]) begin
            if (!found && rules[k].opc == i[6:0] && rules[k].f3 == i[14:12] &&
                (!rules[k].f7_care || rules[k].f7 == i[31:25])) begin
                found = 1'b1;
                op    = rules[k].op;
            end
        end
        e.rd = i[11:7];
        e.op = op;
        if (!found) begin
            e.a = 0; e.b = 0; e.we = 1'b0; e.ill = 1'b1;
        end else begin
            e.a   = r1;
            e.ill = 1'b0;
            e.we  = (i[11:7] != 5'd0);
            if (i[6:0] == 7'b0110011)
                e.b = r2;
            else if (op == ALU_SLLI || op == ALU_SRLI || op == ALU_SRAI)
                e.b = 32'(i[24:20]);
            else
                e.b = {{20{i[31]}}, i[31:20]};
        end
        return e;
    endfunction

    function automatic logic [31:0] enc(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [4:0] rdi, logic [6:0] opc);
        return {f7, rs2, rs1, f3, rdi, opc};
    endfunction

    // Expected output register, advanced by the handshake rules.
    bit   exp_valid = 1'b0;
    exp_t exp_q;

    always @(posedge clk) begin
        if (!rst_n) begin
            exp_valid = 1'b0;
            exp_q     = '{a: 0, b: 0, op: ALU_ILLEGAL, rd: 0, we: 0, ill: 0};
        end else if (instr_valid && (!exp_valid || out_ready)) begin
            exp_valid = 1'b1;
            exp_q     = model(instr, rs1_data, rs2_data);
        end else if (out_ready) begin
            exp_valid = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp_out_valid", 32'(out_valid), 32'(exp_valid));
            check("cmp_instr_ready", 32'(instr_ready), 32'(!exp_valid || out_ready));
            check("cmp_rs1_addr", 32'(rs1_addr), 32'(instr[19:15]));
            check("cmp_rs2_addr", 32'(rs2_addr), 32'(instr[24:20]));
            if (exp_valid) begin
                check("cmp_a", a, exp_q.a);
                check("cmp_b", b, exp_q.b);
                check("cmp_alu_op", 32'(alu_op), 32'(exp_q.op));
                check("cmp_rd", 32'(rd), 32'(exp_q.rd));
                check("cmp_rd_we", 32'(rd_we), 32'(exp_q.we));
                check("cmp_illegal", 32'(illegal), 32'(exp_q.ill));
            end
        end
    end

    task automatic drive(input logic [31:0] i, input logic v, input logic [31:0] r1,
                         input logic [31:0] r2, input logic ordy);
        instr = i; instr_valid = v; rs1_data = r1; rs2_data = r2; out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] mix[14];

    initial begin
        add_rule(7'b0110011, 3'b000, 7'b0000000, 1, ALU_ADD);
        add_rule(7'b0110011, 3'b000, 7'b0100000, 1, ALU_SUB);
        add_rule(7'b0110011, 3'b001, 7'b0000000, 1, ALU_SLL);
        add_rule(7'b0110011, 3'b010, 7'b0000000, 1, ALU_SLT);
        add_rule(7'b0110011, 3'b011, 7'b0000000, 1, ALU_SLTU);
        add_rule(7'b0110011, 3'b100, 7'b0000000, 1, ALU_XOR);
        add_rule(7'b0110011, 3'b101, 7'b0000000, 1, ALU_SRL);
        add_rule(7'b0110011, 3'b101, 7'b0100000, 1, ALU_SRA);
        add_rule(7'b0110011, 3'b110, 7'b0000000, 1, ALU_OR);
        add_rule(7'b0110011, 3'b111, 7'b0000000, 1, ALU_AND);
        add_rule(7'b0010011, 3'b000, 7'b0000000, 0, ALU_ADDI);
        add_rule(7'b0010011, 3'b010, 7'b0000000, 0, ALU_SLTI);
        add_rule(7'b0010011, 3'b011, 7'b0000000, 0, ALU_SLTIU);
        add_rule(7'b0010011, 3'b100, 7'b0000000, 0, ALU_XORI);
        add_rule(7'b0010011, 3'b110, 7'b0000000, 0, ALU_ORI);
        add_rule(7'b0010011, 3'b111, 7'b0000000, 0, ALU_ANDI);
        add_rule(7'b0010011, 3'b001, 7'b0000000, 1, ALU_SLLI);
        add_rule(7'b0010011, 3'b101, 7'b0000000, 1, ALU_SRLI);
        add_rule(7'b0010011, 3'b101, 7'b0100000, 1, ALU_SRAI);

        // Reset state
        rst_n = 1'b0;
        drive(32'h0, 1'b0, 0, 0, 1'b1);
        cmp_en = 1'b1;
        drive(32'h0, 1'b1, 0, 0, 1'b1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_a", a, 32'd0);
        check("rst_b", b, 32'd0);
        check("rst_alu_op", 32'(alu_op), 32'h3F);
        check("rst_rd", 32'(rd), 32'd0);
        check("rst_rd_we", 32'(rd_we), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        rst_n = 1'b1;

        // ADDI x1,x0,5
        drive(32'h00500093, 1'b1, 0, 0, 1'b1);
        check("addi_valid", 32'(out_valid), 32'd1);
        check("addi_op", 32'(alu_op), 32'd10);
        check("addi_a", a, 32'd0);
        check("addi_b", b, 32'd5);
        check("addi_rd", 32'(rd), 32'd1);
        check("addi_we", 32'(rd_we), 32'd1);
        check("addi_ill", 32'(illegal), 32'd0);

        // ADDI x1,x0,-1
        drive(32'hFFF00093, 1'b1, 0, 0, 1'b1);
        check("addi_neg_b", b, 32'hFFFFFFFF);

        // SUB x3,x1,x2
        instr = 32'h402081B3; rs1_data = 10; rs2_data = 3;
        #1;
        check("sub_rs1_addr", 32'(rs1_addr), 32'd1);
        check("sub_rs2_addr", 32'(rs2_addr), 32'd2);
        drive(32'h402081B3, 1'b1, 10, 3, 1'b1);
        check("sub_op", 32'(alu_op), 32'd1);
        check("sub_a", a, 32'd10);
        check("sub_b", b, 32'd3);
        check("sub_rd", 32'(rd), 32'd3);

        // SRAI x5,x6,3
        drive(32'h40335293, 1'b1, 32'h8000_0000, 0, 1'b1);
        check("srai_op", 32'(alu_op), 32'd18);
        check("srai_b", b, 32'd3);
        check("srai_rd", 32'(rd), 32'd5);

        // Stall: ADD x7,x1,x2 accepted, then 3 cycles of backpressure with AND x9 pending
        drive(32'h002083B3, 1'b1, 100, 23, 1'b1);
        for (int c = 0; c < 3; c++) begin
            instr = 32'h0020F4B3; rs1_data = 32'hF0F0; rs2_data = 32'hFF; out_ready = 1'b0;
            #1;
            check("stall_instr_ready", 32'(instr_ready), 32'd0);
            drive(32'h0020F4B3, 1'b1, 32'hF0F0, 32'hFF, 1'b0);
            check("stall_op", 32'(alu_op), 32'd0);
            check("stall_a", a, 32'd100);
            check("stall_b", b, 32'd23);
            check("stall_rd", 32'(rd), 32'd7);
        end
        drive(32'h0020F4B3, 1'b1, 32'hF0F0, 32'hFF, 1'b1);
        check("release_op", 32'(alu_op), 32'd9);
        check("release_a", a, 32'hF0F0);
        check("release_b", b, 32'hFF);
        check("release_rd", 32'(rd), 32'd9);

        // Drain: no new instruction with out_ready=1
        drive(32'h0, 1'b0, 0, 0, 1'b1);
        check("drain_valid", 32'(out_valid), 32'd0);

        // All-zero word is illegal
        drive(32'h00000000, 1'b1, 32'h1234, 32'h5678, 1'b1);
        check("zero_ill", 32'(illegal), 32'd1);
        check("zero_we", 32'(rd_we), 32'd0);
        check("zero_op", 32'(alu_op), 32'h3F);
        check("zero_a", a, 32'd0);
        check("zero_b", b, 32'd0);

        // ADDI x0,x1,7: legal but never writes back
        drive(32'h00708013, 1'b1, 32'd9, 0, 1'b1);
        check("x0_we", 32'(rd_we), 32'd0);
        check("x0_ill", 32'(illegal), 32'd0);

        // Mixed stream with intermittent backpressure, checked against the model
        mix[0]  = enc(7'b0000000, 5'd3, 5'd2, 3'b001, 5'd4, 7'b0110011);
        mix[1]  = enc(7'b0000000, 5'd3, 5'd2, 3'b010, 5'd4, 7'b0110011);
        mix[2]  = enc(7'b0000000, 5'd3, 5'd2, 3'b011, 5'd4, 7'b0110011);
        mix[3]  = enc(7'b0000000, 5'd3, 5'd2, 3'b100, 5'd4, 7'b0110011);
        mix[4]  = enc(7'b0000000, 5'd3, 5'd2, 3'b101, 5'd4, 7'b0110011);
        mix[5]  = enc(7'b0100000, 5'd3, 5'd2, 3'b101, 5'd4, 7'b0110011);
        mix[6]  = enc(7'b0000000, 5'd3, 5'd2, 3'b110, 5'd4, 7'b0110011);
        mix[7]  = enc(7'b0010000, 5'd3, 5'd2, 3'b000, 5'd4, 7'b0110011);
        mix[8]  = enc(7'b1000000, 5'd31, 5'd2, 3'b010, 5'd6, 7'b0010011);
        mix[9]  = enc(7'b0000000, 5'd17, 5'd2, 3'b001, 5'd6, 7'b0010011);
        mix[10] = enc(7'b0100000, 5'd4, 5'd2, 3'b001, 5'd6, 7'b0010011);
        mix[11] = enc(7'b0000000, 5'd9, 5'd2, 3'b101, 5'd6, 7'b0010011);
        mix[12] = enc(7'b1111111, 5'd31, 5'd2, 3'b111, 5'd6, 7'b0010011);
        mix[13] = 32'h000010B7;
        for (int k = 0; k < 14; k++) begin
            drive(mix[k], 1'b1, 32'h1000 + 32'(k), 32'h2000 + 32'(k), (k % 3) != 1);
            while (!instr_ready) drive(mix[k], 1'b1, 32'h1000 + 32'(k), 32'h2000 + 32'(k), 1'b1);
        end

        // Reset during a stall discards the held instruction
        drive(32'h002083B3, 1'b1, 1, 2, 1'b1);
        drive(32'h0020F4B3, 1'b1, 3, 4, 1'b0);
        rst_n = 1'b0;
        drive(32'h0020F4B3, 1'b1, 3, 4, 1'b0);
        check("rst_stall_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        instr_valid = 1'b0;
        #1;
        check("post_rst_ready", 32'(instr_ready), 32'd1);
        drive(32'h00500093, 1'b1, 0, 0, 1'b1);
        check("post_rst_b", b, 32'd5);
        drive(32'h0, 1'b0, 0, 0, 1'b1);

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst_n  input  1  synchronous active-low reset, sampled on clk rising edge.
REQ-004 Port: instr  input  32  RV32I instruction word from fetch.
REQ-005 Port: instr_valid  input  1  instr holds a valid instruction.
REQ-006 Port: instr_ready  output  1  decoder accepts instr this cycle.
REQ-007 Port: rs1_addr, rs2_addr  output  5 each  register-file read addresses, taken combinationally from instr[19:15] and instr[24:20].
REQ-008 Port: rs1_data, rs2_data  input  32 each  register-file read data, combinational, valid in the same cycle.
REQ-009 Port: a, b  output  32 each  registered ALU operands.
REQ-010 Port: alu_op  output  6  registered ALU operation code from the shared constants file.
REQ-011 Port: rd  output  5  destination register; rd_we  output  1  write-back enable.
REQ-012 Port: illegal  output  1  decoded instruction is unsupported.
REQ-013 Port: out_valid  output  1  a, b, alu_op, rd, rd_we and illegal are valid; out_ready  input  1  downstream accepts.

Function
REQ-014 instr_ready SHALL equal (!out_valid || out_ready), combinationally.
REQ-015 A transfer SHALL occur when instr_valid && instr_ready; the decoded result SHALL be registered on that edge and out_valid SHALL be 1 the next cycle (latency 1).
REQ-016 With out_valid=1 and out_ready=0, all outputs SHALL hold unchanged and no instruction SHALL be accepted.
REQ-017 With out_valid=1, out_ready=1 and instr_valid=1, the new result SHALL replace the old on the same edge, giving one instruction per cycle throughput.
REQ-018 With out_valid=1, out_ready=1 and instr_valid=0, out_valid SHALL be 0 next cycle.
REQ-019 Opcode 0110011 (OP): a=rs1_data, b=rs2_data, rd_we=1; funct3/funct7 map to ADD, SUB (funct7=0100000, funct3=000), SLL, SLT, SLTU, XOR, SRL, SRA (funct7=0100000, funct3=101), OR, AND.
REQ-020 Opcode 0010011 (OP-IMM): a=rs1_data, b=sign-extended instr[31:20], rd_we=1; funct3 maps to ADDI, SLTI, SLTIU, XORI, ORI, ANDI.
REQ-021 OP-IMM shifts: SLLI/SRLI/SRAI SHALL set b={27'b0, instr[24:20]}; SRAI when funct7=0100000 and funct3=101.
REQ-022 Any other opcode, or an unlisted funct3/funct7 combination, SHALL set illegal=1, rd_we=0, alu_op=ILLEGAL, a=0, b=0.
REQ-023 rd=0 SHALL force rd_we=0; illegal stays 0 for such instructions.
REQ-024 Handshake signals SHALL never depend combinationally on instr contents.

Reset
REQ-025 While rst_n=0 at a clock edge: out_valid=0, a=0, b=0, alu_op=ILLEGAL, rd=0, rd_we=0, illegal=0.
REQ-026 A reset asserted mid-stall SHALL discard the held instruction; instr_ready SHALL be 1 in the cycle after reset releases.

Structure
REQ-027 The 6-bit alu_op codes, including the new ILLEGAL code (distinct from every ALU operation so the ALU takes its default path), SHALL live in the shared constants file; opcode constants (OP=0110011, OP_IMM=0010011) SHALL be added there too.
REQ-028 A combinational sub-module imm_gen (instr -> 32-bit I-type immediate or shamt) SHALL be used; all other logic SHALL be in decode_stage.

Verification
REQ-029 instr=0x00500093 (ADDI x1,x0,5), rs1_data=0 -> next cycle out_valid=1, alu_op=ADDI, a=0, b=5, rd=1, rd_we=1, illegal=0.
REQ-030 instr=0xFFF00093 (ADDI x1,x0,-1) -> b=0xFFFFFFFF.
REQ-031 instr=0x402081B3 (SUB x3,x1,x2), rs1_data=10, rs2_data=3 -> rs1_addr=1, rs2_addr=2; output alu_op=SUB, a=10, b=3, rd=3.
REQ-032 instr=0x40335293 (SRAI x5,x6,3) -> alu_op=SRAI, b=3, rd=5.
REQ-033 Valid ADD accepted, then out_ready=0 for 3 cycles with a new instr_valid=1 -> instr_ready=0, outputs frozen 3 cycles; out_ready=1 -> new instruction accepted on that edge.
REQ-034 instr=0x00000000 -> illegal=1, rd_we=0, alu_op=ILLEGAL; rst_n=0 during a stall -> out_valid=0 the next cycle.
